fifo_stim_driver: RTL and testbench

- Drives the write/read side of the 64-entry fifo in the RL goal-seeking bench.
- Accepts one action at a time from the agent (op plus burst length) and expands it into cycle-by-cycle push/pop, generating the push data as an incrementing sequence.
- Checks popped data and the fifo count against an internal shadow model.
- Counts full/empty goal events (rising edges) as reward.

---
 rtl/fifo_drv_pkg.sv | 20 ++
 rtl/fifo_stim_driver_if.sv | 29 ++
 rtl/fifo_drv_sat_cnt.sv | 28 ++
 rtl/fifo_stim_driver.sv | 176 +++++++++++++++++
 tb/tb_fifo_stim_driver.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_drv_pkg.sv
// Shared definitions for the fifo stimulus driver: op encoding, FSM states
// and the default fifo geometry.
package fifo_drv_pkg;

    localparam int WIDTH_DEF     = 8;
    localparam int DEPTH_DEF     = 64;
    localparam int LOG2DEPTH_DEF = 6;

    localparam logic [1:0] OP_IDLE  = 2'd0;
    localparam logic [1:0] OP_PUSH  = 2'd1;
    localparam logic [1:0] OP_POP   = 2'd2;
    localparam logic [1:0] OP_MIXED = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/fifo_stim_driver_if.sv
// Connection between the stimulus driver and the fifo under exercise:
// the driver is the master, the fifo is the slave.
interface fifo_stim_driver_if
    import fifo_drv_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int LOG2DEPTH = LOG2DEPTH_DEF
);
    logic                 push;
    logic                 pop;
    logic [WIDTH-1:0]     datain;
    logic                 full;
    logic                 empty;
    logic [LOG2DEPTH:0]   count;
    logic                 full_posedge;
    logic                 empty_posedge;
    logic [WIDTH-1:0]     dataout;

    modport master (
        output push, pop, datain,
        input  full, empty, count, full_posedge, empty_posedge, dataout
    );

    modport slave (
        input  push, pop, datain,
        output full, empty, count, full_posedge, empty_posedge, dataout
    );

endinterface

// File: rtl/fifo_drv_sat_cnt.sv
// Saturating up-counter that can step by 0, 1 or 2 per cycle, with a
// synchronous clear that takes priority over counting.
module fifo_drv_sat_cnt #(
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            clear,
    input  logic [1:0]      inc,
    output logic [CNTW-1:0] value
);

    logic [CNTW:0] sum;

    always_comb begin
        sum = {1'b0, value} + {{(CNTW-1){1'b0}}, inc};
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            value <= '0;
        end else if (sum[CNTW]) begin
            value <= '1;
        end else begin
            value <= sum[CNTW-1:0];
        end
    end

endmodule

// File: rtl/fifo_stim_driver.sv
// Expands agent actions into registered fifo push/pop traffic, checks the fifo
// against a shadow occupancy/sequence model and counts full/empty goal events.
module fifo_stim_driver
    import fifo_drv_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int LOG2DEPTH = LOG2DEPTH_DEF,
    parameter int CNTW      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 action_valid,
    output logic                 action_ready,
    input  logic [1:0]           action_op,
    input  logic [LOG2DEPTH:0]   action_len,
    output logic                 action_done,
    output logic                 done_hit_full,
    output logic                 done_hit_empty,
    fifo_stim_driver_if.master   fifo,
    output logic [CNTW-1:0]      full_hits,
    output logic [CNTW-1:0]      empty_hits,
    output logic                 data_err,
    output logic                 model_err,
    output logic [CNTW-1:0]      err_cnt
);

    localparam logic [LOG2DEPTH:0] DEPTH_V = (LOG2DEPTH+1)'(DEPTH);
    localparam logic [LOG2DEPTH:0] ONE_V   = (LOG2DEPTH+1)'(1);

    state_t               state, state_n;
    logic [1:0]           op_q, op_n, sel_op;
    logic [LOG2DEPTH:0]   rem, rem_n, occ, occ_n;
    logic [WIDTH-1:0]     wr_seq, wr_seq_n, rd_seq, datain_q, datain_n;
    logic                 push_q, pop_q, push_n, pop_n, issue;
    logic                 hit_full_q, hit_empty_q, hit_full_n, hit_empty_n;
    logic                 data_mis, model_mis;
    logic [1:0]           err_inc;

    // Occupancy after this cycle's traffic; it is both the expected fifo count
    // and the basis for next cycle's issue decision.
    always_comb begin
        occ_n = occ + {{LOG2DEPTH{1'b0}}, push_q} - {{LOG2DEPTH{1'b0}}, pop_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        op_n        = op_q;
        rem_n       = rem;
        issue       = 1'b0;
        hit_full_n  = hit_full_q;
        hit_empty_n = hit_empty_q;
        push_n      = 1'b0;
        pop_n       = 1'b0;
        datain_n    = datain_q;
        wr_seq_n    = wr_seq;
        sel_op      = (state == ST_IDLE) ? action_op : op_q;
        case (state)
            ST_IDLE: begin
                if (action_valid) begin
                    op_n        = action_op;
                    rem_n       = action_len;
                    hit_full_n  = 1'b0;
                    hit_empty_n = 1'b0;
                    if (action_len == '0 || action_op == OP_IDLE) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_RUN;
                        issue   = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                rem_n = rem - ONE_V;
                if (fifo.full_posedge)  hit_full_n  = 1'b1;
                if (fifo.empty_posedge) hit_empty_n = 1'b1;
                if (rem == ONE_V) begin
                    state_n = ST_DONE;
                end else begin
                    issue = 1'b1;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        if (issue) begin
            push_n = (sel_op == OP_PUSH || sel_op == OP_MIXED) && (occ_n < DEPTH_V);
            pop_n  = (sel_op == OP_POP  || sel_op == OP_MIXED) && (occ_n != '0);
            if (push_n) begin
                datain_n = wr_seq;
                wr_seq_n = wr_seq + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q        <= OP_IDLE;
            rem         <= '0;
            occ         <= '0;
            wr_seq      <= '0;
            rd_seq      <= '0;
            datain_q    <= '0;
            push_q      <= 1'b0;
            pop_q       <= 1'b0;
            hit_full_q  <= 1'b0;
            hit_empty_q <= 1'b0;
            data_err    <= 1'b0;
            model_err   <= 1'b0;
        end else begin
            op_q        <= op_n;
            rem         <= rem_n;
            occ         <= occ_n;
            wr_seq      <= wr_seq_n;
            rd_seq      <= rd_seq + {{(WIDTH-1){1'b0}}, pop_q};
            datain_q    <= datain_n;
            push_q      <= push_n;
            pop_q       <= pop_n;
            hit_full_q  <= hit_full_n;
            hit_empty_q <= hit_empty_n;
            if (data_mis)  data_err  <= 1'b1;
            if (model_mis) model_err <= 1'b1;
        end
    end

    // Popped data must follow the same incrementing sequence that was pushed.
    always_comb begin
        data_mis  = pop_q && (fifo.dataout != rd_seq);
        model_mis = (fifo.count != occ_n)
                 || (fifo.full  != (occ_n == DEPTH_V))
                 || (fifo.empty != (occ_n == '0));
        err_inc   = {1'b0, data_mis} + {1'b0, model_mis};
    end

    fifo_drv_sat_cnt #(.CNTW(CNTW)) u_full_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   ({1'b0, fifo.full_posedge}),
        .value (full_hits)
    );

    fifo_drv_sat_cnt #(.CNTW(CNTW)) u_empty_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   ({1'b0, fifo.empty_posedge}),
        .value (empty_hits)
    );

    fifo_drv_sat_cnt #(.CNTW(CNTW)) u_err_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (err_inc),
        .value (err_cnt)
    );

    assign fifo.push      = push_q;
    assign fifo.pop       = pop_q;
    assign fifo.datain    = datain_q;
    assign action_ready   = (state == ST_IDLE);
    assign action_done    = (state == ST_DONE);
    assign done_hit_full  = action_done && hit_full_q;
    assign done_hit_empty = action_done && hit_empty_q;

endmodule

// File: tb/tb_fifo_stim_driver.sv
// Bench for fifo_stim_driver: a behavioural 64-entry fifo on the slave side and
// a per-cycle scoreboard of the expected push/pop/datain for every action.
module tb_fifo_stim_driver;
    import fifo_drv_pkg::*;

    localparam int WIDTH     = 8;
    localparam int DEPTH     = 64;
    localparam int LOG2DEPTH = 6;
    localparam int CNTW      = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 action_valid;
    logic                 action_ready;
    logic [1:0]           action_op;
    logic [LOG2DEPTH:0]   action_len;
    logic                 action_done;
    logic                 done_hit_full;
    logic                 done_hit_empty;
    logic [CNTW-1:0]      full_hits;
    logic [CNTW-1:0]      empty_hits;
    logic                 data_err;
    logic                 model_err;
    logic [CNTW-1:0]      err_cnt;

    always #5 clk = ~clk;

    fifo_stim_driver_if #(.WIDTH(WIDTH), .LOG2DEPTH(LOG2DEPTH)) bus ();

    fifo_stim_driver #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .LOG2DEPTH(LOG2DEPTH), .CNTW(CNTW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .action_valid   (action_valid),
        .action_ready   (action_ready),
        .action_op      (action_op),
        .action_len     (action_len),
        .action_done    (action_done),
        .done_hit_full  (done_hit_full),
        .done_hit_empty (done_hit_empty),
        .fifo           (bus),
        .full_hits      (full_hits),
        .empty_hits     (empty_hits),
        .data_err       (data_err),
        .model_err      (model_err),
        .err_cnt        (err_cnt)
    );

    // Behavioural fifo: count is the next-state count, posedges are level vs. previous cycle.
    logic [WIDTH-1:0]     mem [DEPTH];
    logic [LOG2DEPTH-1:0] wp, rp;
    logic [LOG2DEPTH:0]   occ_f;
    logic                 full_prev, empty_prev;
    int                   pops_seen;
    int                   corrupt_at = -1;

    assign bus.count         = occ_f + {{LOG2DEPTH{1'b0}}, bus.push} - {{LOG2DEPTH{1'b0}}, bus.pop};
    assign bus.full          = (bus.count == 7'(DEPTH));
    assign bus.empty         = (bus.count == 7'd0);
    assign bus.full_posedge  = bus.full && !full_prev;
    assign bus.empty_posedge = bus.empty && !empty_prev;
    assign bus.dataout       = mem[rp] ^ ((pops_seen == corrupt_at) ? 8'hA5 : 8'h00);

    always @(posedge clk) begin
        if (rst) begin
            occ_f      <= '0;
            wp         <= '0;
            rp         <= '0;
            full_prev  <= 1'b0;
            empty_prev <= 1'b1;
            pops_seen  <= 0;
        end else begin
            if (bus.push) begin
                mem[wp] <= bus.datain;
                wp      <= wp + 6'd1;
            end
            if (bus.pop) begin
                rp        <= rp + 6'd1;
                pops_seen <= pops_seen + 1;
            end
            occ_f      <= bus.count;
            full_prev  <= bus.full;
            empty_prev <= bus.empty;
        end
    end

    typedef struct packed {
        logic             push;
        logic             pop;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   occ_m = 0;
    int   wr_m = 0;
    int   exp_full_hits = 0;
    int   exp_empty_hits = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Starts at a negedge with the driver idle; returns at the negedge after action_ready is back.
    task automatic applyStimulus(input logic [1:0] op, input int len);
        int   waited;
        int   nxt;
        logic hf, he;
        exp_t e;
        waited = 0;
        while (!action_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("ready_before_action", action_ready, 1);
        hf = 1'b0;
        he = 1'b0;
        if (op != OP_IDLE) begin
            for (int i = 0; i < len; i++) begin
                e.push = (op == OP_PUSH || op == OP_MIXED) && (occ_m < DEPTH);
                e.pop  = (op == OP_POP  || op == OP_MIXED) && (occ_m > 0);
                e.data = e.push ? wr_m[WIDTH-1:0] : '0;
                if (e.push) wr_m++;
                nxt = occ_m + int'(e.push) - int'(e.pop);
                if (nxt == DEPTH && occ_m != DEPTH) begin
                    hf = 1'b1;
                    exp_full_hits++;
                end
                if (nxt == 0 && occ_m != 0) begin
                    he = 1'b1;
                    exp_empty_hits++;
                end
                occ_m = nxt;
                exp_q.push_back(e);
            end
        end
        action_valid = 1'b1;
        action_op    = op;
        action_len   = len[LOG2DEPTH:0];
        @(negedge clk);
        action_valid = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("push", bus.push, e.push);
            checkOutput("pop", bus.pop, e.pop);
            if (e.push) checkOutput("datain", bus.datain, e.data);
            checkOutput("done_during_run", action_done, 0);
            @(negedge clk);
        end
        checkOutput("action_done", action_done, 1);
        checkOutput("done_hit_full", done_hit_full, hf);
        checkOutput("done_hit_empty", done_hit_empty, he);
        checkOutput("push_in_done", bus.push, 0);
        checkOutput("pop_in_done", bus.pop, 0);
        @(negedge clk);
        checkOutput("ready_after_done", action_ready, 1);
    endtask

    task automatic checkCounters(input string tag, input int exp_err);
        checkOutput({tag, "_full_hits"}, full_hits, exp_full_hits);
        checkOutput({tag, "_empty_hits"}, empty_hits, exp_empty_hits);
        checkOutput({tag, "_model_err"}, model_err, 0);
        checkOutput({tag, "_err_cnt"}, err_cnt, exp_err);
        checkOutput({tag, "_data_err"}, data_err, (exp_err != 0) ? 1 : 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        action_valid = 1'b0;
        action_op    = OP_IDLE;
        action_len   = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", action_ready, 1);
        checkOutput("rst_push", bus.push, 0);
        checkOutput("rst_pop", bus.pop, 0);
        checkOutput("rst_datain", bus.datain, 0);
        checkOutput("rst_done", action_done, 0);
        checkCounters("rst", 0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(OP_PUSH, 64);
        checkCounters("fill", 0);
        applyStimulus(OP_PUSH, 3);
        applyStimulus(OP_POP, 70);
        checkCounters("drain", 0);

        applyStimulus(OP_PUSH, 10);
        applyStimulus(OP_MIXED, 20);
        checkOutput("mixed_count", bus.count, 10);
        checkCounters("mixed", 0);

        corrupt_at = pops_seen + 2;
        applyStimulus(OP_POP, 5);
        corrupt_at = -1;
        checkCounters("corrupt", 1);
        applyStimulus(OP_MIXED, 4);
        checkCounters("after_corrupt", 1);

        action_valid = 1'b1;
        action_op    = OP_PUSH;
        action_len   = 7'd30;
        @(negedge clk);
        action_valid = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("push_before_reset", bus.push, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        occ_m = 0;
        wr_m = 0;
        exp_full_hits = 0;
        exp_empty_hits = 0;
        exp_q.delete();
        checkOutput("midrst_push", bus.push, 0);
        checkOutput("midrst_ready", action_ready, 1);
        checkCounters("midrst", 0);

        applyStimulus(OP_PUSH, 3);
        applyStimulus(OP_PUSH, 0);
        applyStimulus(OP_IDLE, 4);
        applyStimulus(OP_POP, 5);
        checkCounters("short_drain", 0);
        applyStimulus(OP_PUSH, 70);
        applyStimulus(OP_MIXED, 3);
        checkCounters("final", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
